// File: rtl/riscv_pkg.sv
// Shared RISC-V EX-stage definitions.
// Purpose : ALUOp encodings, ALU control codes, funct3/funct7 names, the
//           RV32M operation enum, the multiply/divide FSM state enum, and the
//           base funct3 -> ALU code mapping used by R- and I-type decode.
// Ports   : none (package).
package riscv_pkg;

  // ALUOp from main control.
  localparam logic [2:0] ALUOP_LS  = 3'b000;  // load/store address add
  localparam logic [2:0] ALUOP_B   = 3'b001;  // branch compare
  localparam logic [2:0] ALUOP_R   = 3'b010;  // register-register
  localparam logic [2:0] ALUOP_I   = 3'b011;  // register-immediate
  localparam logic [2:0] ALUOP_LUI = 3'b100;  // pass operand B

  // ALU control codes. Code 0 is reserved for "no operation / undefined",
  // which is also what an M op drives onto the ALU.
  localparam logic [3:0] ALU_NONE  = 4'd0;
  localparam logic [3:0] ALU_ADD   = 4'd1;
  localparam logic [3:0] ALU_SUB   = 4'd2;
  localparam logic [3:0] ALU_SLL   = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_SLTU  = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_OR    = 4'd9;
  localparam logic [3:0] ALU_AND   = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;

  // funct3 values; the suffix is the funct3 value itself.
  localparam logic [2:0] F3_TYPE0 = 3'd0;  // ADD/SUB, BEQ, MUL
  localparam logic [2:0] F3_TYPE1 = 3'd1;  // SLL, BNE
  localparam logic [2:0] F3_TYPE2 = 3'd2;  // SLT
  localparam logic [2:0] F3_TYPE3 = 3'd3;  // SLTU
  localparam logic [2:0] F3_TYPE4 = 3'd4;  // XOR, BLT
  localparam logic [2:0] F3_TYPE5 = 3'd5;  // SRL/SRA, BGE
  localparam logic [2:0] F3_TYPE6 = 3'd6;  // OR, BLTU
  localparam logic [2:0] F3_TYPE7 = 3'd7;  // AND, BGEU

  localparam logic [6:0] F7_TYPE0  = 7'b0000000;
  localparam logic [6:0] F7_TYPE32 = 7'b0100000;
  localparam logic [6:0] F7_TYPE1  = 7'b0000001;  // RV32M group

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE, MD_CALC, MD_DONE
  } md_state_e;

  // funct3 -> ALU code for the funct7 = 0 flavour of R/I-type ops.
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      F3_TYPE0: code = ALU_ADD;
      F3_TYPE1: code = ALU_SLL;
      F3_TYPE2: code = ALU_SLT;
      F3_TYPE3: code = ALU_SLTU;
      F3_TYPE4: code = ALU_XOR;
      F3_TYPE5: code = ALU_SRL;
      F3_TYPE6: code = ALU_OR;
      default:  code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide datapath.
// Purpose : holds the working {hi, lo} pair and the latched second operand,
//           and advances UNROLL bits of shift-add multiply or restoring divide
//           per step. Operands are unsigned magnitudes; sign handling is done
//           by the caller.
//   multiply: lo starts as the multiplier, hi accumulates; final {hi,lo} is
//             the 2*XLEN product.
//   divide  : lo starts as the dividend and ends as the quotient; hi ends as
//             the remainder.
// Ports   : i_Clk, i_Rst_n   clock, async active-low reset
//           i_Load           load i_A/i_B/i_IsDiv, clear hi
//           i_Step           commit one UNROLL-bit step
//           i_IsDiv          operation kind captured on load
//           i_A, i_B         multiplier/dividend, multiplicand/divisor
//           o_HiNxt, o_LoNxt value of {hi,lo} after the step in progress
module md_iter_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_Load,
  input  logic            i_Step,
  input  logic            i_IsDiv,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  output logic [XLEN-1:0] o_HiNxt,
  output logic [XLEN-1:0] o_LoNxt
);

  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic            r_is_div;

  logic [XLEN-1:0] w_hi, w_lo, w_addend;
  logic [XLEN:0]   w_sum, w_shift;

  always_comb begin
    w_hi     = r_hi;
    w_lo     = r_lo;
    w_addend = '0;
    w_sum    = '0;
    w_shift  = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (r_is_div) begin
        // Shift the next dividend bit into the partial remainder. The
        // subtraction is done on XLEN bits: when it is taken the true
        // difference is below r_b, so the dropped top bit is always zero.
        w_shift = {w_hi, w_lo[XLEN-1]};
        w_lo    = {w_lo[XLEN-2:0], 1'b0};
        if (w_shift >= {1'b0, r_b}) begin
          w_hi    = w_shift[XLEN-1:0] - r_b;
          w_lo[0] = 1'b1;
        end else begin
          w_hi    = w_shift[XLEN-1:0];
        end
      end else begin
        w_addend = w_lo[0] ? r_b : '0;
        w_sum    = {1'b0, w_hi} + {1'b0, w_addend};
        w_lo     = {w_sum[0], w_lo[XLEN-1:1]};
        w_hi     = w_sum[XLEN:1];
      end
    end
  end

  assign o_HiNxt = w_hi;
  assign o_LoNxt = w_lo;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
    end else if (i_Load) begin
      r_hi     <= '0;
      r_lo     <= i_A;
      r_b      <= i_B;
      r_is_div <= i_IsDiv;
    end else if (i_Step) begin
      r_hi     <= w_hi;
      r_lo     <= w_lo;
    end
  end

endmodule

// File: rtl/md_alu_ctrl.sv
// EX-stage ALU control decoder with an RV32M multiply/divide engine.
// Purpose : combinational RV32I ALU control decode; RV32M ops run on an
//           iterative engine that stalls the pipeline and returns the result
//           with a one-cycle done strobe.
// Ports   : i_Clk, i_Rst_n        clock, async active-low reset
//           i_ALUOp/i_Funct3/i_Funct7  instruction decode fields
//           i_Valid, i_Flush       EX instruction valid / kill
//           i_OpA, i_OpB           rs1/rs2 operands
//           o_ALUControlLines      ALU control code (0 for M ops/undefined)
//           o_IsMD                 instruction is an M op
//           o_Stall                hold IF/ID/EX
//           o_MDResult, o_MDDone   registered M-op result and its strobe
//
// Handshake: an M op is taken when i_Valid && o_IsMD && !i_Flush in IDLE.
// From that cycle o_Stall holds the instruction in EX until the DONE cycle,
// where o_Stall drops and o_MDDone/o_MDResult are presented so the
// instruction retires as the pipeline advances. DONE never takes a new op.
module md_alu_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic [2:0]      i_ALUOp,
  input  logic [2:0]      i_Funct3,
  input  logic [6:0]      i_Funct7,
  input  logic            i_Valid,
  input  logic            i_Flush,
  input  logic [XLEN-1:0] i_OpA,
  input  logic [XLEN-1:0] i_OpB,
  output logic [3:0]      o_ALUControlLines,
  output logic            o_IsMD,
  output logic            o_Stall,
  output logic [XLEN-1:0] o_MDResult,
  output logic            o_MDDone
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       r_state, w_state_nxt;
  logic [CW-1:0]   r_iter;
  md_op_e          r_op;
  logic            r_neg;
  logic [XLEN-1:0] r_result;

  // ---------------- decode ----------------
  logic [3:0] w_lines;
  logic       w_is_md;

  always_comb begin
    w_lines = ALU_NONE;
    w_is_md = (i_ALUOp == ALUOP_R) && (i_Funct7 == F7_TYPE1);
    case (i_ALUOp)
      ALUOP_LS:  w_lines = ALU_ADD;
      ALUOP_B: begin
        case (i_Funct3)
          F3_TYPE0, F3_TYPE1: w_lines = ALU_SUB;
          F3_TYPE4, F3_TYPE5: w_lines = ALU_SLT;
          F3_TYPE6, F3_TYPE7: w_lines = ALU_SLTU;
          default:            w_lines = ALU_NONE;
        endcase
      end
      ALUOP_R: begin
        if (i_Funct7 == F7_TYPE0)
          w_lines = alu_base(i_Funct3);
        else if (i_Funct7 == F7_TYPE32 && i_Funct3 == F3_TYPE0)
          w_lines = ALU_SUB;
        else if (i_Funct7 == F7_TYPE32 && i_Funct3 == F3_TYPE5)
          w_lines = ALU_SRA;
      end
      ALUOP_I: begin
        // Only the shift immediates carry funct7; all others ignore it.
        if (i_Funct3 == F3_TYPE1)
          w_lines = (i_Funct7 == F7_TYPE0) ? ALU_SLL : ALU_NONE;
        else if (i_Funct3 == F3_TYPE5)
          w_lines = (i_Funct7 == F7_TYPE0)  ? ALU_SRL :
                    (i_Funct7 == F7_TYPE32) ? ALU_SRA : ALU_NONE;
        else
          w_lines = alu_base(i_Funct3);
      end
      ALUOP_LUI: w_lines = ALU_PASSB;
      default:   w_lines = ALU_NONE;
    endcase
    if (w_is_md) w_lines = ALU_NONE;
  end

  assign o_ALUControlLines = w_lines;
  assign o_IsMD            = w_is_md;

  // ---------------- operand preparation ----------------
  md_op_e          w_op;
  logic            w_a_neg, w_b_neg, w_res_neg;
  logic            w_div_zero, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res;

  assign w_op = md_op_e'(i_Funct3);

  always_comb begin
    w_a_neg = i_OpA[XLEN-1] && (w_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    w_b_neg = i_OpB[XLEN-1] && (w_op inside {MD_MULH, MD_DIV, MD_REM});
    // MUL low half is sign-independent; remainder takes the dividend's sign.
    case (w_op)
      MD_MULH, MD_MULHSU, MD_DIV: w_res_neg = w_a_neg ^ w_b_neg;
      MD_REM:                     w_res_neg = w_a_neg;
      default:                    w_res_neg = 1'b0;
    endcase
    w_mag_a = w_a_neg ? -i_OpA : i_OpA;
    w_mag_b = w_b_neg ? -i_OpB : i_OpB;

    w_div_zero = i_Funct3[2] && (i_OpB == '0);
    w_ovf      = (w_op inside {MD_DIV, MD_REM}) && (i_OpA == MIN_NEG) && (i_OpB == '1);
    w_special  = w_div_zero || w_ovf;
    if (w_div_zero)
      w_special_res = (w_op inside {MD_DIV, MD_DIVU}) ? '1 : i_OpA;
    else
      w_special_res = (w_op == MD_DIV) ? MIN_NEG : '0;
  end

  assign w_accept = (r_state == MD_IDLE) && i_Valid && w_is_md && !i_Flush;

  // ---------------- iterative engine ----------------
  logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_fix_res;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  md_iter_unit #(.XLEN(XLEN), .UNROLL(UNROLL)) u_iter (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Load  (w_accept && !w_special),
    .i_Step  ((r_state == MD_CALC) && !i_Flush),
    .i_IsDiv (i_Funct3[2]),
    .i_A     (w_mag_a),
    .i_B     (w_mag_b),
    .o_HiNxt (w_hi_nxt),
    .o_LoNxt (w_lo_nxt)
  );

  // Sign fix-up applied to the engine's state after the final step.
  always_comb begin
    w_prod     = {w_hi_nxt, w_lo_nxt};
    w_prod_fix = r_neg ? -w_prod : w_prod;
    case (r_op)
      MD_MUL:                       w_fix_res = w_prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_fix_res = r_neg ? -w_lo_nxt : w_lo_nxt;
      default:                      w_fix_res = r_neg ? -w_hi_nxt : w_hi_nxt;
    endcase
  end

  // ---------------- FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) w_state_nxt = w_special ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (i_Flush)                 w_state_nxt = MD_IDLE;
        else if (r_iter == CW'(1))   w_state_nxt = MD_DONE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state  <= MD_IDLE;
      r_iter   <= '0;
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= w_op;
        r_neg <= w_res_neg;
        if (w_special) r_result <= w_special_res;
        else           r_iter   <= CW'(N);
      end else if ((r_state == MD_CALC) && !i_Flush) begin
        r_iter <= r_iter - CW'(1);
        if (r_iter == CW'(1)) r_result <= w_fix_res;
      end
    end
  end

  // Reset is included so the pipeline is never held while in reset.
  assign o_Stall    = i_Rst_n && !i_Flush &&
                      (((r_state == MD_IDLE) && i_Valid && w_is_md) || (r_state == MD_CALC));
  assign o_MDResult = r_result;
  assign o_MDDone   = (r_state == MD_DONE);

endmodule

// File: tb/tb_md_alu_ctrl.sv
module tb_md_alu_ctrl;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_Rst_n;
  logic [2:0]  i_ALUOp, i_Funct3;
  logic [6:0]  i_Funct7;
  logic        i_Valid, i_Flush;
  logic [31:0] i_OpA, i_OpB;
  logic [3:0]  o_ALUControlLines;
  logic        o_IsMD, o_Stall, o_MDDone;
  logic [31:0] o_MDResult;

  md_alu_ctrl #(.XLEN(32), .UNROLL(1)) dut (
    .i_Clk             (clk),
    .i_Rst_n           (i_Rst_n),
    .i_ALUOp           (i_ALUOp),
    .i_Funct3          (i_Funct3),
    .i_Funct7          (i_Funct7),
    .i_Valid           (i_Valid),
    .i_Flush           (i_Flush),
    .i_OpA             (i_OpA),
    .i_OpB             (i_OpB),
    .o_ALUControlLines (o_ALUControlLines),
    .o_IsMD            (o_IsMD),
    .o_Stall           (o_Stall),
    .o_MDResult        (o_MDResult),
    .o_MDDone          (o_MDDone)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf)        return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf)        return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_ALUOp  = ALUOP_R;
    i_Funct7 = F7_TYPE1;
    i_Funct3 = op;
    i_OpA    = a;
    i_OpB    = b;
    i_Valid  = 1'b1;
  endtask

  task automatic check_decode(input string tag, input logic [2:0] aluop, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [3:0] exp_lines);
    @(negedge clk);
    i_ALUOp = aluop; i_Funct3 = f3; i_Funct7 = f7; i_Valid = 1'b1;
    i_OpA = $urandom; i_OpB = $urandom;
    #1;
    check({tag, " lines"}, 64'(o_ALUControlLines), 64'(exp_lines));
    check({tag, " ismd/stall"}, 64'({o_IsMD, o_Stall}), 64'(2'b00));
  endtask

  // Accept an M op and follow it cycle by cycle to its DONE cycle.
  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    lat = is_special(op, a, b) ? 1 : 33;
    @(negedge clk);
    drive_md(op, a, b);
    #1;
    check({name, " accept ismd/stall/lines"},
          64'({o_IsMD, o_Stall, o_ALUControlLines}), 64'({1'b1, 1'b1, ALU_NONE}));
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Operands and funct fields change under the in-flight op.
        i_Valid  = 1'b0;
        i_OpA    = $urandom;
        i_OpB    = $urandom;
        i_Funct3 = 3'($urandom_range(0, 7));
      end
      #1;
      check($sformatf("%s c+%0d stall/done", name, k),
            64'({o_Stall, o_MDDone}), 64'({k < lat, k == lat}));
      if (k == lat) check({name, " result"}, 64'(o_MDResult), 64'(exp));
    end
    last_res = exp;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          mode;

    // Reset with an M op presented: no stall, cleared outputs.
    i_Rst_n = 1'b0;
    i_Flush = 1'b0;
    drive_md(3'd0, 32'd9, 32'd9);
    #2;
    check("reset stall/done", 64'({o_Stall, o_MDDone}), 64'(2'b00));
    check("reset result", 64'(o_MDResult), 64'(0));
    @(negedge clk);
    @(negedge clk);
    i_Valid = 1'b0;
    i_Rst_n = 1'b1;
    last_res = 32'd0;

    // RV32I decode.
    check_decode("R add",   ALUOP_R,   3'd0, F7_TYPE0,  ALU_ADD);
    check_decode("R sub",   ALUOP_R,   3'd0, F7_TYPE32, ALU_SUB);
    check_decode("B sltu",  ALUOP_B,   3'd6, F7_TYPE0,  ALU_SLTU);
    check_decode("I srai",  ALUOP_I,   3'd5, F7_TYPE32, ALU_SRA);
    check_decode("LS add",  ALUOP_LS,  3'd3, 7'h55,     ALU_ADD);
    check_decode("R undef", ALUOP_R,   3'd1, F7_TYPE32, ALU_NONE);
    check_decode("op undef", 3'b111,   3'd0, F7_TYPE0,  ALU_NONE);

    // M ops from the directed table (back-to-back acceptance between them).
    run_md("MUL",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_md("MULHU",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("MULH",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
    run_md("MULHSU", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("DIV",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_md("REM",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_md("DIVU",   3'd5, 32'd100,        32'd7,         32'h0000_000E);
    run_md("REMU",   3'd7, 32'd100,        32'd7,         32'h0000_0002);
    run_md("DIV/0",  3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF);
    run_md("REM/0",  3'd6, 32'd5,          32'd0,         32'h0000_0005);
    run_md("DIVovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_md("REMovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);

    // Randomized ops against the reference model.
    for (int t = 0; t < 24; t++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0) r_b = 32'd0;
      if (mode == 1) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
      if (mode == 2) begin r_a = 32'($urandom_range(0, 255)); r_b = 32'($urandom_range(1, 15)); end
      if (mode == 3) r_b = r_b | 32'h8000_0000;
      run_md($sformatf("rnd%0d op%0d", t, r_op), r_op, r_a, r_b, md_ref(r_op, r_a, r_b));
    end

    // Flush at c+10: back to IDLE at c+11, no done, result unchanged.
    @(negedge clk);
    drive_md(3'd0, 32'h1234, 32'h5678);
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) i_Valid = 1'b0;
      i_Flush = (k == 10);
      #1;
      if (k == 10) check("flush c+10 stall", 64'(o_Stall), 64'(0));
      if (k == 11) check("flush c+11 stall/done/result",
                         64'({o_Stall, o_MDDone, o_MDResult}), 64'({1'b0, 1'b0, last_res}));
      if (k > 11)  check($sformatf("flush c+%0d done", k), 64'(o_MDDone), 64'(0));
    end

    // Reset at c+5 abandons the op; outputs clear immediately.
    @(negedge clk);
    drive_md(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    i_Rst_n = 1'b0;
    #1;
    check("rst c+5 stall/done", 64'({o_Stall, o_MDDone}), 64'(2'b00));
    check("rst c+5 result", 64'(o_MDResult), 64'(0));
    @(negedge clk);
    i_Valid = 1'b0;
    i_Rst_n = 1'b1;
    run_md("MUL after reset", 3'd0, 32'd3, 32'd4, 32'h0000_000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_alu_ctrl.md
# md_alu_ctrl

Parametrised successor to the EX-stage ALU control decoder. It produces the same 4-bit ALU control lines for RV32I ALUOp/funct3/funct7 combinations. It also decodes the RV32M group (R-type, funct7 = 0000001) and executes those ops on an iterative multiply/divide engine. While an M op is in flight it stalls the pipeline through `o_Stall` and returns the result with a one-cycle `o_MDDone` strobe.

## Interface
- `XLEN`, 32: operand/result width; must be even and at least 8.
- `UNROLL`, 1: bits processed per iteration; one of 1, 2, 4; `XLEN % UNROLL == 0`.
- `i_Clk`  in  1  clock; all state updates on the rising edge.
- `i_Rst_n`  in  1  reset; asynchronous, active-low.
- `i_ALUOp`  in  3  ALUOp from main control.
- `i_Funct3`  in  3  instruction funct3.
- `i_Funct7`  in  7  instruction funct7.
- `i_Valid`  in  1  the instruction in EX is valid.
- `i_Flush`  in  1  kill the EX instruction and any in-flight M op.
- `i_OpA`, `i_OpB`  in  XLEN  rs1/rs2 operands.
- `o_ALUControlLines`  out  4  ALU control code.
- `o_IsMD`  out  1  decoded instruction is an M op.
- `o_Stall`  out  1  hold IF/ID/EX.
- `o_MDResult`  out  XLEN  M-op result.
- `o_MDDone`  out  1  `o_MDResult` valid this cycle.

## Operation
- **Decode.** Combinational; RV32I mapping is identical to the previous generation, with all undefined combinations → `4'b0`.
- **M-op detection.** `o_IsMD = (ALUOp == ALUOP_R) && (funct7 == F7_TYPE1)`. When set, `o_ALUControlLines = 4'b0`.
- **M-op table (funct3).**
  - 0 MUL: low XLEN bits.
  - 1 MULH: signed×signed, high half.
  - 2 MULHSU: signed×unsigned, high half.
  - 3 MULHU: unsigned×unsigned, high half.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- **FSM states:** IDLE, CALC, DONE.
- **IDLE.**
  - Accept condition: `i_Valid && o_IsMD && !i_Flush`. On accept, latch op, operand magnitudes and result sign.
  - Divisor = 0, or signed overflow (DIV/REM of −2^(XLEN−1) by −1): go straight to DONE.
  - Otherwise go to CALC with `iter = XLEN/UNROLL`.
- **CALC.** Shift-add multiply or restoring divide, `UNROLL` bits per cycle; `iter` decrements. When `iter == 1`, go to DONE, loading the sign-corrected result into `o_MDResult`.
- **DONE.**
  - `o_MDDone = 1`; `o_MDResult` is held.
  - Always go to IDLE next; DONE never accepts a new op.
  - A back-to-back M op is accepted in the following IDLE cycle.
- **Special results.**
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow: quotient = −2^(XLEN−1), remainder = 0.
  - REM sign follows the dividend.
- **Stall.** `o_Stall = !i_Flush && ((IDLE && i_Valid && o_IsMD) || CALC)`. It is low in DONE, so the pipeline advances on the cycle `o_MDDone` is high.
- **Flush.** `i_Flush` in any state → IDLE next cycle, with no `o_MDDone` and `o_MDResult` unchanged.
- **Ignored inputs.** In CALC and DONE, `i_OpA`, `i_OpB`, `i_Funct*` and `i_ALUOp` are ignored for the M op; the latched values are used.
- **Reset values.** State IDLE, `iter` 0, `o_MDResult` 0, `o_MDDone` 0. During reset `o_Stall` = 0. Reset mid-CALC abandons the op.

## Timing
- `o_ALUControlLines`, `o_IsMD` and `o_Stall` are combinational. `o_MDResult` and `o_MDDone` are registered.
- **Normal op, accepted in cycle c:**
  - CALC occupies c+1 … c+N, where N = XLEN/UNROLL.
  - DONE, with `o_MDDone` high, in cycle c+N+1.
  - `o_Stall` is high for N+1 cycles (c … c+N).
- **Special case (divide by zero, signed overflow):** DONE in c+1; 1 stall cycle.
- Non-M instructions never stall and add no latency.

## Structure
- **Shared package** (`riscv_pkg`): ALUOP_*, ALU_*, F3_TYPE*, F7_TYPE0/32, plus a new `F7_TYPE1 = 7'b0000001`. Also `md_op_e` (8 M ops) and `md_state_e` (IDLE/CALC/DONE).
- **Sub-module `md_iter_unit`:** operand/product/remainder registers and the per-iteration shift-add/subtract step, generated for `UNROLL`.
- **Top level:** decoder, FSM, counter, sign fix-up.

## Test plan
Default parameters; cycle c = accept cycle.
- **RV32I decode:** ALUOp R, f3=0, f7=0 → ALU_ADD; f7=0x20 → ALU_SUB; f7=0x01 → `o_IsMD`=1, lines `4'b0`; ALUOP_B f3=6 → ALU_SLTU; in all these, `o_Stall`=0 except the M case.
- **MUL:** 7 × 0xFFFFFFFD → `o_MDResult` 0xFFFFFFEB with `o_MDDone` in c+33; `o_Stall` high c…c+32, low at c+33.
- **High-half multiplies:** 0xFFFFFFFF × 0xFFFFFFFF → MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
- **Divide:** DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 0xE; REMU → 0x2; all done at c+33.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 0x5, done at c+1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, done at c+1.
- **Interruptions:**
  - `i_Flush` at c+10 → IDLE at c+11, no `o_MDDone`, `o_Stall` low.
  - `i_Rst_n` low at c+5 → outputs 0 immediately.
  - After release, a new MUL 3×4 → 0xC at c'+33.
